// File: rtl/regfile_wb_arbiter.sv
// Writeback scheduler for a dual-write-port register file.
// Grants up to two results per cycle oldest-first and never issues two writes to the same register in one cycle.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int XLEN  = 32,
  parameter int SEQ_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [5*N_REQ-1:0]     req_rd,
  input  logic [XLEN*N_REQ-1:0]  req_data,
  input  logic [SEQ_W*N_REQ-1:0] req_seq,
  input  logic                   flush,
  output logic                   we1,
  output logic                   we2,
  output logic [4:0]             waddr1,
  output logic [4:0]             waddr2,
  output logic [XLEN-1:0]        wdata1,
  output logic [XLEN-1:0]        wdata2,
  output logic [31:0]            wb_count
);

  logic [4:0]       rd_a   [N_REQ];
  logic [XLEN-1:0]  data_a [N_REQ];
  logic [SEQ_W-1:0] seq_a  [N_REQ];
  logic [2:0]       rank   [N_REQ];

  logic [N_REQ-1:0] g0_oh, g1_oh;
  logic             has_g0, has_g1;
  logic [4:0]       g0_rd, g1_rd;
  logic [XLEN-1:0]  g0_data, g1_data;

  logic             nxt_we1, nxt_we2, ld1, ld2;
  logic [4:0]       nxt_a1, nxt_a2;
  logic [XLEN-1:0]  nxt_d1, nxt_d2;

  // a is older than b when (a - b) mod 2^SEQ_W has its MSB set
  function automatic logic is_older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] diff;
    diff = a - b;
    return diff[SEQ_W-1];
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rd_a[i]   = req_rd[5*i +: 5];
      data_a[i] = req_data[XLEN*i +: XLEN];
      seq_a[i]  = req_seq[SEQ_W*i +: SEQ_W];
    end
  end

  // Rank of a valid requester = number of valid requesters older than it.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rank[i] = '0;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (j != i && req_valid[j] && is_older(seq_a[j], seq_a[i]))
          rank[i] = rank[i] + 3'd1;
      end
    end
  end

  always_comb begin
    g0_oh   = '0;
    g1_oh   = '0;
    g0_rd   = '0;
    g1_rd   = '0;
    g0_data = '0;
    g1_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      g0_oh[i] = req_valid[i] && (rank[i] == 3'd0);
      g1_oh[i] = req_valid[i] && (rank[i] == 3'd1);
      if (g0_oh[i]) begin
        g0_rd   = g0_rd | rd_a[i];
        g0_data = g0_data | data_a[i];
      end
      if (g1_oh[i]) begin
        g1_rd   = g1_rd | rd_a[i];
        g1_data = g1_data | data_a[i];
      end
    end
    has_g0 = |g0_oh;
    has_g1 = |g1_oh;
  end

  always_comb begin
    if (!rst_n)
      req_ready = '0;
    else if (flush)
      req_ready = req_valid;
    else
      req_ready = g0_oh | g1_oh;
  end

  // A same-rd pair collapses onto port1 carrying the younger result; the older one is acknowledged and dropped.
  always_comb begin
    nxt_we1 = 1'b0;
    nxt_we2 = 1'b0;
    ld1     = 1'b0;
    ld2     = 1'b0;
    nxt_a1  = g0_rd;
    nxt_d1  = g0_data;
    nxt_a2  = g1_rd;
    nxt_d2  = g1_data;
    if (!flush && has_g0) begin
      ld1 = 1'b1;
      if (has_g1 && (g0_rd == g1_rd)) begin
        nxt_a1  = g1_rd;
        nxt_d1  = g1_data;
        nxt_we1 = (g1_rd != 5'd0);
      end else begin
        nxt_we1 = (g0_rd != 5'd0);
        if (has_g1) begin
          ld2     = 1'b1;
          nxt_we2 = (g1_rd != 5'd0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we1      <= 1'b0;
      we2      <= 1'b0;
      waddr1   <= '0;
      waddr2   <= '0;
      wdata1   <= '0;
      wdata2   <= '0;
      wb_count <= '0;
    end else begin
      we1 <= nxt_we1;
      we2 <= nxt_we2;
      if (ld1) begin
        waddr1 <= nxt_a1;
        wdata1 <= nxt_d1;
      end
      if (ld2) begin
        waddr2 <= nxt_a2;
        wdata2 <= nxt_d2;
      end
      wb_count <= wb_count + {31'd0, nxt_we1} + {31'd0, nxt_we2};
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: per-scenario tasks push expected writes,
// and a monitor pops them one edge later.
module tb_regfile_wb_arbiter;

  localparam int N_REQ = 3;
  localparam int XLEN  = 32;
  localparam int SEQ_W = 6;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [5*N_REQ-1:0]     req_rd;
  logic [XLEN*N_REQ-1:0]  req_data;
  logic [SEQ_W*N_REQ-1:0] req_seq;
  logic                   flush;
  logic                   we1, we2;
  logic [4:0]             waddr1, waddr2;
  logic [XLEN-1:0]        wdata1, wdata2;
  logic [31:0]            wb_count;

  regfile_wb_arbiter #(.N_REQ(N_REQ), .XLEN(XLEN), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .req_seq(req_seq), .flush(flush),
    .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
    .wdata1(wdata1), .wdata2(wdata2), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we1;
    logic        we2;
    logic        chk1;
    logic        chk2;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = 0;

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if ({we1, we2} !== {mon_e.we1, mon_e.we2})
        $display("FAIL %s we: got %b%b want %b%b", mon_e.name, we1, we2, mon_e.we1, mon_e.we2);
      else n_pass++;
      if (mon_e.chk1) begin
        n_checks++;
        if ({waddr1, wdata1} !== {mon_e.a1, mon_e.d1})
          $display("FAIL %s port1: got %0d/%h want %0d/%h", mon_e.name, waddr1, wdata1, mon_e.a1, mon_e.d1);
        else n_pass++;
      end
      if (mon_e.chk2) begin
        n_checks++;
        if ({waddr2, wdata2} !== {mon_e.a2, mon_e.d2})
          $display("FAIL %s port2: got %0d/%h want %0d/%h", mon_e.name, waddr2, wdata2, mon_e.a2, mon_e.d2);
        else n_pass++;
      end
      n_checks++;
      if (wb_count !== mon_e.cnt)
        $display("FAIL %s wb_count: got %0d want %0d", mon_e.name, wb_count, mon_e.cnt);
      else n_pass++;
    end
  end

  task automatic set_req(input int i, input logic v, input logic [4:0] rd,
                         input logic [SEQ_W-1:0] seq, input logic [31:0] data);
    req_valid[i]              = v;
    req_rd[5*i +: 5]          = rd;
    req_seq[SEQ_W*i +: SEQ_W] = seq;
    req_data[XLEN*i +: XLEN]  = data;
  endtask

  task automatic expect_ready(input string name, input logic [N_REQ-1:0] want);
    #1;
    n_checks++;
    if (req_ready !== want)
      $display("FAIL %s ready: got %b want %b", name, req_ready, want);
    else n_pass++;
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    set_req(0, 1'b1, 5'd1, 6'd0, 32'h1);
    set_req(1, 1'b1, 5'd2, 6'd1, 32'h2);
    set_req(2, 1'b1, 5'd3, 6'd2, 32'h3);
    expect_ready("reset", 3'b000);
    @(posedge clk);
    #1;
    n_checks++;
    if ({we1, we2, waddr1, waddr2, wdata1, wdata2, wb_count} !== '0)
      $display("FAIL reset outputs: got we=%b%b a=%0d/%0d cnt=%0d want all zero", we1, we2, waddr1, waddr2, wb_count);
    else n_pass++;
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  task automatic test_three_valid();
    @(negedge clk);
    set_req(0, 1'b1, 5'd1, 6'd5, 32'hAAAA_0001);
    set_req(1, 1'b1, 5'd2, 6'd3, 32'hBBBB_0002);
    set_req(2, 1'b1, 5'd3, 6'd4, 32'hCCCC_0003);
    expect_ready("three_c0", 3'b110);
    exp_cnt += 2;
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 5'd3, 32'hBBBB_0002, 32'hCCCC_0003, exp_cnt, "three_c0"});
    @(negedge clk);
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b0;
    expect_ready("three_c1", 3'b001);
    exp_cnt += 1;
    sb.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 32'hAAAA_0001, 32'h0, exp_cnt, "three_c1"});
    @(negedge clk);
    req_valid = '0;
    expect_ready("idle", 3'b000);
    sb.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd3, 32'hAAAA_0001, 32'hCCCC_0003, exp_cnt, "idle_hold"});
  endtask

  task automatic test_collision();
    @(negedge clk);
    set_req(0, 1'b1, 5'd7, 6'd10, 32'h11);
    set_req(1, 1'b1, 5'd7, 6'd11, 32'h22);
    req_valid[2] = 1'b0;
    expect_ready("collision", 3'b011);
    exp_cnt += 1;
    sb.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 32'h22, 32'h0, exp_cnt, "collision"});
    go_idle();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    set_req(0, 1'b1, 5'd4, 6'd62, 32'h6200);
    set_req(1, 1'b1, 5'd5, 6'd1, 32'h0100);
    req_valid[2] = 1'b0;
    expect_ready("wrap2", 3'b011);
    exp_cnt += 2;
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 5'd5, 32'h6200, 32'h0100, exp_cnt, "wrap2"});
    @(negedge clk);
    set_req(0, 1'b1, 5'd4, 6'd62, 32'h6201);
    set_req(1, 1'b1, 5'd5, 6'd1, 32'h0101);
    set_req(2, 1'b1, 5'd6, 6'd63, 32'h6301);
    expect_ready("wrap3_c0", 3'b101);
    exp_cnt += 2;
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 5'd6, 32'h6201, 32'h6301, exp_cnt, "wrap3_c0"});
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_valid[2] = 1'b0;
    expect_ready("wrap3_c1", 3'b010);
    exp_cnt += 1;
    sb.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 32'h0101, 32'h0, exp_cnt, "wrap3_c1"});
    go_idle();
  endtask

  task automatic test_rd_zero();
    @(negedge clk);
    set_req(0, 1'b1, 5'd0, 6'd2, 32'h0202);
    req_valid[1] = 1'b0;
    set_req(2, 1'b1, 5'd9, 6'd3, 32'h0909);
    expect_ready("rd0_diff", 3'b101);
    exp_cnt += 1;
    sb.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd9, 32'h0, 32'h0909, exp_cnt, "rd0_diff"});
    @(negedge clk);
    set_req(0, 1'b1, 5'd0, 6'd4, 32'h0404);
    set_req(1, 1'b1, 5'd0, 6'd5, 32'h0505);
    req_valid[2] = 1'b0;
    expect_ready("rd0_same", 3'b011);
    sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, exp_cnt, "rd0_same"});
    go_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_req(0, 1'b1, 5'd10, 6'd20, 32'hD0);
    set_req(1, 1'b1, 5'd11, 6'd21, 32'hD1);
    set_req(2, 1'b1, 5'd12, 6'd22, 32'hD2);
    expect_ready("b2b_c0", 3'b011);
    exp_cnt += 2;
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 5'd11, 32'hD0, 32'hD1, exp_cnt, "b2b_c0"});
    @(negedge clk);
    set_req(0, 1'b1, 5'd13, 6'd23, 32'hD3);
    req_valid[1] = 1'b0;
    expect_ready("b2b_c1", 3'b101);
    exp_cnt += 2;
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 5'd13, 32'hD2, 32'hD3, exp_cnt, "b2b_c1"});
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 5'd12, 6'd24, 32'hD4);
    set_req(2, 1'b1, 5'd12, 6'd25, 32'hD5);
    expect_ready("b2b_c2", 3'b110);
    exp_cnt += 1;
    sb.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 5'd0, 32'hD5, 32'h0, exp_cnt, "b2b_c2"});
    go_idle();
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_req(0, 1'b1, 5'd20, 6'd40, 32'hF0);
    set_req(1, 1'b1, 5'd21, 6'd41, 32'hF1);
    set_req(2, 1'b1, 5'd22, 6'd42, 32'hF2);
    flush = 1'b1;
    expect_ready("flush", 3'b111);
    sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, exp_cnt, "flush"});
    go_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(0, 1'b1, 5'd14, 6'd30, 32'hE0);
    set_req(1, 1'b1, 5'd15, 6'd31, 32'hE1);
    req_valid[2] = 1'b0;
    expect_ready("pre_reset", 3'b011);
    exp_cnt += 2;
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 5'd14, 5'd15, 32'hE0, 32'hE1, exp_cnt, "pre_reset"});
    @(negedge clk);
    set_req(0, 1'b1, 5'd16, 6'd32, 32'hE2);
    set_req(1, 1'b0, 5'd0, 6'd0, 32'h0);
    set_req(2, 1'b1, 5'd17, 6'd33, 32'hE3);
    #2;
    rst_n = 1'b0;
    expect_ready("mid_reset", 3'b000);
    n_checks++;
    if ({we1, we2, waddr1, wdata1, wb_count} !== '0)
      $display("FAIL mid_reset async: got we=%b%b a1=%0d cnt=%0d want zero", we1, we2, waddr1, wb_count);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({we1, we2, wb_count} !== '0)
      $display("FAIL mid_reset held: got we=%b%b cnt=%0d want zero", we1, we2, wb_count);
    else n_pass++;
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    exp_cnt   = 0;
    @(negedge clk);
    set_req(0, 1'b1, 5'd18, 6'd34, 32'hE4);
    expect_ready("post_reset", 3'b001);
    exp_cnt += 1;
    sb.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'd18, 5'd0, 32'hE4, 32'h0, exp_cnt, "post_reset"});
    go_idle();
  endtask

  initial begin
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    req_seq   = '0;
    test_reset();
    test_three_valid();
    test_collision();
    test_wrap();
    test_rd_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
